// File: rtl/aes_pkg.sv
// Shared AES definitions: block width and serializer state encoding.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W = 128;

    typedef enum logic {
        IDLE,
        STREAM
    } serializer_state_t;

    function automatic int unsigned beat_count(input int unsigned out_w);
        return AES_BLOCK_W / out_w;
    endfunction

endpackage

// File: rtl/aes_block_fifo.sv
// Synchronous FIFO of 128-bit blocks; the read port always shows the head entry.
module aes_block_fifo
    import aes_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [AES_BLOCK_W-1:0]   i_data,
    output logic [AES_BLOCK_W-1:0]   o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [AES_BLOCK_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wp;
    logic [PTR_W-1:0]       r_rp;
    logic [CNT_W-1:0]       r_count;
    logic                   w_do_push;
    logic                   w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_head    = r_mem[r_rp];
    assign o_count   = r_count;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wp] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wp <= r_wp + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rp <= r_rp + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/aes_cipher_serializer.sv
// Buffers AES ciphertext blocks and streams them MSB-first as OUT_W-bit beats.
module aes_cipher_serializer
    import aes_pkg::*;
#(
    parameter int unsigned OUT_W = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AES_BLOCK_W-1:0]   cipher_in,
    input  logic                     cipher_valid,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     overflow,
    input  logic                     overflow_clr,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned BEATS = beat_count(OUT_W);
    localparam int unsigned BI_W  = $clog2(BEATS);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [BI_W-1:0] LAST_BI = BI_W'(BEATS - 1);

    serializer_state_t      r_state;
    logic [BI_W-1:0]        r_bi;
    logic                   r_overflow;

    logic [AES_BLOCK_W-1:0] w_head;
    logic [OUT_W-1:0]       w_beat;
    logic [CNT_W-1:0]       w_count;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_is_last;
    logic                   w_xfer;
    logic                   w_pop;
    logic                   w_push_ok;
    logic                   w_drop;

    aes_block_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (cipher_valid),
        .i_pop   (w_pop),
        .i_data  (cipher_in),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_is_last = (r_bi == LAST_BI);
    assign w_xfer    = (r_state == STREAM) & out_ready;
    assign w_pop     = w_xfer & w_is_last & ~w_empty;
    assign w_push_ok = cipher_valid & (~w_full | w_pop);
    assign w_drop    = cipher_valid & w_full & ~w_pop;

    // Beat 0 is the most significant slice (FIPS-197 byte 0 first).
    always_comb begin
        w_beat = '0;
        for (int i = 0; i < int'(BEATS); i++) begin
            if (r_bi == BI_W'(i)) begin
                w_beat = w_head[AES_BLOCK_W-1-i*OUT_W -: OUT_W];
            end
        end
    end

    assign out_valid = (r_state == STREAM);
    assign out_last  = out_valid & w_is_last;
    assign out_data  = out_valid ? w_beat : '0;
    assign overflow  = r_overflow;
    assign level     = w_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_bi       <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (overflow_clr) begin
                r_overflow <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_push_ok) begin
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_xfer) begin
                        if (w_is_last) begin
                            r_bi <= '0;
                            if (w_count == CNT_W'(1) && !w_push_ok) begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_bi <= r_bi + BI_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/aes_cipher_serializer.md
# aes_cipher_serializer

Downstream stage of the AES core. Captures each 128-bit ciphertext block on the core's one-cycle completion pulse, buffers up to DEPTH blocks, and streams them out as OUT_W-bit beats over a valid/ready handshake. The core never stalls; when the buffer is full, a block is dropped and a sticky overflow flag records the loss.

## Interface
- OUT_W, 8: output beat width; legal values 8, 16, 32, 64. BEATS = 128/OUT_W.
- DEPTH, 2: buffered blocks; power of two, at least 2.
- clk  in  1  the design clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cipher_in  in  128  ciphertext from the AES core; sampled only when cipher_valid=1.
- cipher_valid  in  1  one-cycle completion pulse from the core.
- out_data  out  OUT_W  current beat.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts the beat; a transfer is out_valid & out_ready.
- out_last  out  1  the current beat is the final beat of its block.
- overflow  out  1  sticky; a block was dropped because the buffer was full.
- overflow_clr  in  1  synchronous clear of overflow.
- level  out  $clog2(DEPTH)+1  number of blocks held, including the one streaming.

## Operation
- Storage: DEPTH x 128 register array, write pointer wp, read pointer rp, occupancy count; beat index bi counts 0..BEATS-1.
- Push: when cipher_valid=1 and count<DEPTH, write mem[wp] and increment wp (wraps mod DEPTH).
- Full-buffer push: when cipher_valid=1 and count==DEPTH with no pop in the same cycle, drop the block and set overflow.
- FSM states and transitions:
  - IDLE (count==0): out_valid=0. A push moves the FSM to STREAM.
  - STREAM: out_valid=1, out_data = mem[rp][127-bi*OUT_W -: OUT_W], so the most significant beat (FIPS-197 byte 0) goes first.
  - out_last=1 when bi==BEATS-1.
- Transfer, not last: bi increments.
- Transfer on the last beat: bi returns to 0, the entry pops, and rp increments (wraps). The FSM goes to IDLE if count becomes 0, otherwise it stays in STREAM and starts the next block with no bubble.
- Push and pop in the same cycle: count is unchanged. This includes the full case: the pop frees the slot, so the push is accepted and overflow is not set.
- out_data and out_last stay stable while out_valid=1 and out_ready=0.
- overflow_clr and an overflow event in the same cycle: overflow stays set (the set wins).
- level = count.

## Timing
- Reset values: out_valid=0, out_last=0, out_data=0, overflow=0, level=0, wp=rp=bi=0, FSM=IDLE.
- Reset is asynchronous, and buffered blocks are lost. Reset in mid-block discards the partial block; after release, no stale beats appear.
- Latency: with a push at edge N into an empty buffer, out_valid=1 and beat 0 appear in cycle N+1.
- A block takes BEATS accepted cycles to drain. Throughput is one beat per cycle while out_ready=1.
- Back-to-back blocks (the core's minimum spacing is larger than BEATS for OUT_W≥8 and DEPTH≥2) never overflow while out_ready is held at 1.
- Outputs are driven from registers through the beat mux only. There is no combinational path from out_ready to out_valid or out_data.

## Structure
- Shared package aes_pkg: AES_BLOCK_W=128 and the state enum serializer_state_t {IDLE, STREAM}. The core and future AES stages reuse both.
- One sub-module, aes_block_fifo: generic 128-bit synchronous FIFO with push/pop, full/empty/count, and a read port fixed on head.
- The top level holds the beat counter, FSM, beat mux, and overflow logic.

## Test plan
- Single block: push cipher_in=0x3925841d02dc09fbdc118597196a0b32 with out_ready=1 and OUT_W=8. Expect 16 beats 0x39,0x25,…,0x32 in cycles N+1..N+16, out_last only on 0x32, level back to 0 at N+17.
- Backpressure: same block, toggle out_ready 1,0,0,1,…. Expect out_data unchanged during the low cycles, the full 16-byte sequence delivered in order, and no duplicate or skipped beats.
- Overflow: hold out_ready=0 and push blocks A, B, C. Expect level=2, overflow=1 after C, and a later drain that yields A then B only. Then pulse overflow_clr and expect overflow=0.
- Simultaneous push/pop at full: hold out_ready so A's last beat transfers in the same cycle as C's push. Expect overflow to stay 0 and the output order A, B, C.
- Reset mid-block: assert rst after 5 beats of A. Expect all outputs at reset values immediately. After release, push D and expect D beat 0 first.
- Width variant: OUT_W=32, same vector as the first scenario. Expect beats 0x3925841d, 0x02dc09fb, 0xdc118597, 0x196a0b32, with out_last on the 4th.
